rx_field_parser: RTL and testbench
==================================

// Module: rx_field_parser
// PURPOSE
//  Parametrised UART response parser: scans the received byte stream for a fixed ASCII tag
//  (default "+SPO2="), then captures a decimal field of up to MAX_DIGITS characters
//  terminated by CR (0x0D).
//  Publishes the field atomically as padded ASCII plus a binary value, with valid, null and
//  error flags.
//  Sits between the UART receiver (byte + done strobe) and the display/processing logic.
// PARAMETERS
//  PREFIX_LEN  6           number of tag characters
//  PREFIX      "+SPO2="    tag, 8*PREFIX_LEN bits; first character in the most significant byte
//  MAX_DIGITS  3           maximum field characters captured
//  BIN_W       10          width of the binary value; must hold 10**MAX_DIGITS-1
//  NULL_CHAR   8'h4E ('N') first field char meaning "no reading"
//  FILL_CHAR   8'h3A (':') pad for unused ASCII slots on short fields
//  NULL_FILL   8'h2F ('/') value of every ASCII slot on a null field
//  TIMEOUT_CYC 0           idle clocks between bytes before a frame is abandoned; 0 disables
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 synchronous, active-high reset
//  rx_byte      in   8                 received byte, qualified by rx_done
//  rx_done      in   1                 one-cycle strobe: rx_byte is valid
//  field_ascii  out  8*MAX_DIGITS      captured characters; first char in the most significant byte
//  field_bin    out  BIN_W             decimal value of the field
//  field_len    out  clog2(MAX_DIGITS+1)  digits in the last committed field
//  field_null   out  1                 last committed field was NULL_CHAR (level)
//  field_valid  out  1                 one-cycle pulse on each commit (normal or null)
//  frame_err    out  1                 one-cycle pulse on a discarded frame
//  busy         out  1                 high in every state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE, match index 0. Field outputs at reset:
//    field_ascii all FILL_CHAR; field_bin 0; field_len 0.
//    Flags at reset: field_null, field_valid, frame_err, busy all 0. Shadow registers cleared.
//  - Only cycles with rx_done=1 advance the FSM; rx_byte is ignored otherwise.
//  - States: IDLE (idx 0) -> MATCH (0<idx<PREFIX_LEN) -> FIELD -> SKIP.
//  - MATCH: byte equal to PREFIX[idx] increments idx; reaching PREFIX_LEN enters FIELD and
//    clears the shadow registers.
//    Mismatch sets idx to 1 if the byte equals PREFIX[0], otherwise to 0 (IDLE).
//  - FIELD, first byte NULL_CHAR: commit immediately, then go to IDLE.
//    On commit: field_ascii all NULL_FILL; field_bin 0; field_len 0; field_null 1.
//  - FIELD, digit '0'..'9': shadow char stored in the next slot; acc <= acc*10 + (byte-8'h30);
//    count is incremented.
//  - FIELD, a (MAX_DIGITS+1)th digit: frame_err, then go to SKIP.
//  - FIELD, CR with count>=1: commit and go to IDLE.
//    On commit: field_ascii = shadow chars, with unused trailing slots set to FILL_CHAR;
//    field_bin = acc; field_len = count; field_null = 0.
//  - FIELD, CR with count=0: frame_err, then go to IDLE.
//  - FIELD, any other byte: frame_err, then go to SKIP.
//  - SKIP: discard bytes until CR, then go to IDLE. No output change.
//  - Commit/err timing: outputs are registered on the clock edge that samples the terminating
//    rx_done. field_valid / frame_err are high for exactly the following cycle.
//    field_valid and frame_err are never both 1 in the same cycle.
//  - Field outputs change only on commit; an errored frame leaves the previous field intact.
//  - Timeout (TIMEOUT_CYC>0): the counter runs in MATCH/FIELD/SKIP, clears on every rx_done,
//    and resets on entry to IDLE.
//    When it reaches TIMEOUT_CYC: frame_err pulse, then go to IDLE.
//    If rx_done and the timeout coincide, the byte wins and the counter clears.
//  - rst in any state aborts the frame in progress with no pulse; all outputs return to reset values.
// TESTING
//  - "+SPO2=98\r" -> field_valid 1 cycle; field_ascii={"9","8",":"}; field_bin=98; field_len=2;
//    field_null=0.
//  - "+SPO2=N" -> field_valid; field_ascii={"/","/","/"}; field_bin=0; field_null=1.
//    Next "+SPO2=7\r" clears field_null.
//  - "++SPO2=100\r" -> prefix rematch; field_bin=100; field_ascii="100".
//    Then "+SPO2=1000\r" -> frame_err; outputs stay at 100.
//  - "+SPO2=9x\r" and "+SPO2=\r" -> one frame_err each; no field_valid. busy is 0 after the CR.
//  - TIMEOUT_CYC=50, send "+SPO2=9" then idle 50 clocks -> frame_err, busy=0.
//    Then "+SPO2=42\r" commits 42.
//  - Assert rst while in FIELD after "+SPO2=5" -> all outputs at reset values, no pulses.
//    Then "5\r" alone produces no field_valid.

Source files
------------

// File: rtl/rx_field_parser.sv
// Scans a UART byte stream for a fixed ASCII tag, then captures a CR-terminated decimal
// field and publishes it atomically as padded ASCII plus binary, with valid/null/error flags.
module rx_field_parser #(
    parameter int                      PREFIX_LEN  = 6,
    parameter logic [8*PREFIX_LEN-1:0] PREFIX      = "+SPO2=",
    parameter int                      MAX_DIGITS  = 3,
    parameter int                      BIN_W       = 10,
    parameter logic [7:0]              NULL_CHAR   = 8'h4E,
    parameter logic [7:0]              FILL_CHAR   = 8'h3A,
    parameter logic [7:0]              NULL_FILL   = 8'h2F,
    parameter int                      TIMEOUT_CYC = 0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [7:0]                        i_rx_byte,
    input  logic                              i_rx_done,
    output logic [8*MAX_DIGITS-1:0]           o_field_ascii,
    output logic [BIN_W-1:0]                  o_field_bin,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   o_field_len,
    output logic                              o_field_null,
    output logic                              o_field_valid,
    output logic                              o_frame_err,
    output logic                              o_busy
);

    localparam int         IDX_W    = $clog2(PREFIX_LEN + 1);
    localparam int         CNT_W    = $clog2(MAX_DIGITS + 1);
    localparam int         TMO_W    = $clog2(TIMEOUT_CYC + 2);
    localparam int         TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] PFX0     = PREFIX[8*(PREFIX_LEN-1) +: 8];

    typedef enum logic [1:0] {S_IDLE, S_MATCH, S_FIELD, S_SKIP} state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [8*MAX_DIGITS-1:0] r_sh_ascii;
    logic [BIN_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [TMO_W-1:0]        r_tmo;
    logic [8*MAX_DIGITS-1:0] r_field_ascii;
    logic [BIN_W-1:0]        r_field_bin;
    logic [CNT_W-1:0]        r_field_len;
    logic                    r_field_null;
    logic                    r_field_valid;
    logic                    r_frame_err;

    logic [7:0]              w_pfx_char;
    logic                    w_is_digit;
    logic [BIN_W-1:0]        w_acc_next;
    logic [8*MAX_DIGITS-1:0] w_commit_ascii;
    logic                    w_tmo;

    always_comb begin
        w_pfx_char = PFX0;
        for (int i = 0; i < PREFIX_LEN; i++)
            if (r_idx == IDX_W'(i)) w_pfx_char = PREFIX[8*(PREFIX_LEN-1-i) +: 8];
    end

    assign w_is_digit = (i_rx_byte >= 8'h30) && (i_rx_byte <= 8'h39);
    assign w_acc_next = r_acc * BIN_W'(10) + BIN_W'(i_rx_byte - 8'h30);

    // Slots past the captured count are padded so short fields read left-aligned.
    always_comb begin
        w_commit_ascii = '0;
        for (int i = 0; i < MAX_DIGITS; i++)
            w_commit_ascii[8*(MAX_DIGITS-1-i) +: 8] =
                (CNT_W'(i) < r_cnt) ? r_sh_ascii[8*(MAX_DIGITS-1-i) +: 8] : FILL_CHAR;
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_tmo = (TIMEOUT_CYC > 0) && (r_state != S_IDLE) && !i_rx_done &&
                   (r_tmo == TMO_W'(TMO_LAST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_sh_ascii    <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_tmo         <= '0;
            r_field_ascii <= {MAX_DIGITS{FILL_CHAR}};
            r_field_bin   <= '0;
            r_field_len   <= '0;
            r_field_null  <= 1'b0;
            r_field_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_field_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (r_state == S_IDLE || i_rx_done)
                r_tmo <= '0;
            else if (TIMEOUT_CYC > 0)
                r_tmo <= r_tmo + 1'b1;

            if (w_tmo) begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
                r_idx       <= '0;
            end else if (i_rx_done) begin
                case (r_state)
                    S_IDLE, S_MATCH: begin
                        if (i_rx_byte == w_pfx_char) begin
                            if (r_idx == IDX_W'(PREFIX_LEN-1)) begin
                                r_state    <= S_FIELD;
                                r_idx      <= '0;
                                r_sh_ascii <= '0;
                                r_acc      <= '0;
                                r_cnt      <= '0;
                            end else begin
                                r_state <= S_MATCH;
                                r_idx   <= r_idx + 1'b1;
                            end
                        end else if (i_rx_byte == PFX0) begin
                            r_state <= S_MATCH;
                            r_idx   <= IDX_W'(1);
                        end else begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                        end
                    end
                    S_FIELD: begin
                        if (r_cnt == '0 && i_rx_byte == NULL_CHAR) begin
                            r_field_ascii <= {MAX_DIGITS{NULL_FILL}};
                            r_field_bin   <= '0;
                            r_field_len   <= '0;
                            r_field_null  <= 1'b1;
                            r_field_valid <= 1'b1;
                            r_state       <= S_IDLE;
                        end else if (w_is_digit) begin
                            if (r_cnt == CNT_W'(MAX_DIGITS)) begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_SKIP;
                            end else begin
                                for (int i = 0; i < MAX_DIGITS; i++)
                                    if (r_cnt == CNT_W'(i))
                                        r_sh_ascii[8*(MAX_DIGITS-1-i) +: 8] <= i_rx_byte;
                                r_acc <= w_acc_next;
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else if (i_rx_byte == CR) begin
                            if (r_cnt != '0) begin
                                r_field_ascii <= w_commit_ascii;
                                r_field_bin   <= r_acc;
                                r_field_len   <= r_cnt;
                                r_field_null  <= 1'b0;
                                r_field_valid <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_SKIP;
                        end
                    end
                    S_SKIP: begin
                        if (i_rx_byte == CR) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_field_ascii = r_field_ascii;
    assign o_field_bin   = r_field_bin;
    assign o_field_len   = r_field_len;
    assign o_field_null  = r_field_null;
    assign o_field_valid = r_field_valid;
    assign o_frame_err   = r_frame_err;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rx_field_parser.sv
// Directed bench for rx_field_parser: expected commit/error events are queued as frames
// are sent and compared by a monitor whenever the parser pulses.
module tb_rx_field_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_done;
    logic [23:0] field_ascii;
    logic [9:0]  field_bin;
    logic [1:0]  field_len;
    logic        field_null, field_valid, frame_err, busy;

    typedef struct {
        logic        is_err;
        logic [23:0] ascii;
        logic [9:0]  bin;
        logic [1:0]  len;
        logic        nul;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    logic [23:0] m_ascii = 24'h3A3A3A;
    logic [9:0]  m_bin   = '0;
    logic [1:0]  m_len   = '0;
    logic        m_null  = 1'b0;

    rx_field_parser #(.TIMEOUT_CYC(50)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_byte(rx_byte), .i_rx_done(rx_done),
        .o_field_ascii(field_ascii), .o_field_bin(field_bin), .o_field_len(field_len),
        .o_field_null(field_null), .o_field_valid(field_valid), .o_frame_err(frame_err),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_valid(input logic [23:0] a, input logic [9:0] b,
                              input logic [1:0] l, input logic n);
        exp_t e;
        m_ascii = a; m_bin = b; m_len = l; m_null = n;
        e.is_err = 1'b0; e.ascii = a; e.bin = b; e.len = l; e.nul = n;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.ascii = m_ascii; e.bin = m_bin; e.len = m_len; e.nul = m_null;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_str(input string s, input bit cr);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        if (cr) send_byte(8'h0D);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_ascii"}, field_ascii, m_ascii);
        chk({tag, "_bin"}, field_bin, m_bin);
        chk({tag, "_len"}, field_len, m_len);
        chk({tag, "_null"}, field_null, m_null);
    endtask

    // Scoreboard monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (field_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {field_valid, frame_err}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", {field_valid, frame_err}, e.is_err ? 2'b01 : 2'b10);
                chk("ev_ascii", field_ascii, e.ascii);
                chk("ev_bin", field_bin, e.bin);
                chk("ev_len", field_len, e.len);
                chk("ev_null", field_null, e.nul);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; rx_done = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk_fields("reset");
        chk("reset_valid", field_valid, 1'b0);
        chk("reset_err", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;

        push_valid(24'h39383A, 10'd98, 2'd2, 1'b0);
        send_str("+SPO2=98", 1);
        drain("f98");

        send_str("+SPO2", 0);
        @(negedge clk);
        chk("match_busy", busy, 1'b1);
        push_valid(24'h2F2F2F, 10'd0, 2'd0, 1'b1);
        send_str("=N", 0);
        drain("fnull");

        push_valid(24'h373A3A, 10'd7, 2'd1, 1'b0);
        send_str("+SPO2=7", 1);
        drain("f7");

        push_valid(24'h313030, 10'd100, 2'd3, 1'b0);
        send_str("++SPO2=100", 1);
        drain("f100");

        push_err();
        send_str("+SPO2=1000", 1);
        drain("toolong");
        chk_fields("toolong_keep");

        push_err();
        send_str("+SPO2=9x", 1);
        drain("badchar");

        push_err();
        send_str("+SPO2=", 1);
        drain("empty");

        push_err();
        send_str("+SPO2=3N", 1);
        drain("latenull");

        push_valid(24'h353A3A, 10'd5, 2'd1, 1'b0);
        send_str("AB+S+SPO2=5", 1);
        drain("noise");

        push_err();
        send_str("+SPO2=9", 0);
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                k = i;
                break;
            end
        end
        chk("tmo_cycles", k, 50);
        chk("tmo_busy", busy, 1'b0);

        push_valid(24'h34323A, 10'd42, 2'd2, 1'b0);
        send_str("+SPO2=42", 1);
        drain("f42");

        send_str("+SPO2=5", 0);
        @(negedge clk);
        chk("field_busy", busy, 1'b1);
        rst = 1'b1;
        m_ascii = 24'h3A3A3A; m_bin = '0; m_len = '0; m_null = 1'b0;
        @(negedge clk);
        chk_fields("midrst");
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        send_str("5", 1);
        drain("after_rst");
        chk_fields("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
